// File: rtl/watch_pkg.sv
// Shared constants, FSM state type and 7-segment decode for the watch display path.
package watch_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic MODE_TIME = 1'b0;
    localparam logic MODE_DATE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV0 = 2'd1,
        ST_CONV1 = 2'd2,
        ST_CONV2 = 2'd3
    } conv_state_t;

    // Active-high gfedcba patterns
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // BCD nibble to active-high segments; non-decimal nibbles are blanked
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 12-bit binary to 4-digit BCD converter (double dabble).
// One load cycle, then twelve add-3/shift cycles; done pulses with bcd valid.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    logic [27:0] r_sh;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic        r_done;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left
    function automatic logic [27:0] dabble_step(input logic [27:0] v);
        logic [27:0] t;
        t = v;
        for (int n = 0; n < 4; n++) begin
            if (t[12 + 4*n +: 4] >= 4'd5) begin
                t[12 + 4*n +: 4] = t[12 + 4*n +: 4] + 4'd3;
            end else begin
                t[12 + 4*n +: 4] = t[12 + 4*n +: 4];
            end
        end
        return {t[26:0], 1'b0};
    endfunction

    // Load on start (restarting any run in progress), then iterate twelve times
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= 28'd0;
            r_cnt  <= 4'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_sh   <= {16'd0, bin};
            r_cnt  <= 4'd0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_sh   <= dabble_step(r_sh);
            r_cnt  <= r_cnt + 4'd1;
            r_busy <= (r_cnt != 4'd11);
            r_done <= (r_cnt == 4'd11);
        end else begin
            r_done <= 1'b0;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_sh[27:12];

endmodule

// File: rtl/watch_display_scan.sv
// Six-digit multiplexed 7-segment scanner for the time/date page.
// Each frame boundary snapshots the selected page and converts it to BCD;
// the result is shown from the following frame boundary on (one-frame lag).
module watch_display_scan
    import watch_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter bit SEG_ACT_LO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [11:0] year,
    input  logic [3:0]  month,
    input  logic [4:0]  day,
    input  logic [5:0]  hour,
    input  logic [5:0]  minute,
    input  logic [5:0]  second,
    output logic [7:0]  seg,
    output logic [5:0]  an,
    output logic        busy
);

    localparam int             PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]     IDX_LAST   = 3'(NUM_DIGITS - 1);
    localparam logic [7:0]     SEG_OFF    = SEG_ACT_LO ? 8'hFF : 8'h00;
    localparam logic [5:0]     AN_OFF     = SEG_ACT_LO ? 6'h3F : 6'h00;

    logic [PW-1:0]           r_presc;
    logic [2:0]              r_idx;
    logic                    r_first;
    logic                    w_wrap;
    logic                    w_frame;

    conv_state_t             r_state;
    conv_state_t             w_state_nxt;
    logic                    r_kick;
    logic                    w_kick_nxt;
    logic                    r_busy;
    logic                    w_done_ok;

    logic                    r_snap_mode;
    logic [11:0]             r_snap0;
    logic [11:0]             r_snap1;
    logic [11:0]             r_snap2;
    logic [11:0]             w_bin;

    logic [15:0]             r_work;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_pend_mode;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic                    r_disp_mode;

    logic                    w_bcd_busy;
    logic                    w_bcd_done;
    logic [15:0]             w_bcd;
    logic                    w_unused;

    logic [3:0]              w_nib;
    logic [5:0]              w_an_raw;
    logic                    w_dp;
    logic [7:0]              w_seg_raw;

    assign w_wrap    = (r_presc == PRESC_LAST);
    assign w_frame   = r_first | (w_wrap & (r_idx == IDX_LAST));
    assign w_done_ok = w_bcd_done & ~r_kick;
    assign w_unused  = ^{w_bcd[15:8], w_bcd_busy};

    // Arm a capture for the first cycle out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first <= 1'b1;
        end else begin
            r_first <= 1'b0;
        end
    end

    // Prescaler and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= 3'd0;
        end else if (w_wrap) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Frame boundary: publish pending digits and snapshot the selected page
    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp      <= '0;
            r_disp_mode <= MODE_TIME;
            r_snap_mode <= MODE_TIME;
            r_snap0     <= 12'd0;
            r_snap1     <= 12'd0;
            r_snap2     <= 12'd0;
        end else if (w_frame) begin
            r_disp      <= r_pend;
            r_disp_mode <= r_pend_mode;
            r_snap_mode <= mode;
            r_snap0     <= (mode == MODE_DATE) ? {7'd0, day}   : {6'd0, second};
            r_snap1     <= (mode == MODE_DATE) ? {8'd0, month} : {6'd0, minute};
            r_snap2     <= (mode == MODE_DATE) ? year          : {6'd0, hour};
        end else begin
            r_disp      <= r_disp;
            r_disp_mode <= r_disp_mode;
        end
    end

    // Conversion FSM state, start strobe and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_kick  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_kick  <= w_kick_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Conversion FSM next state; a frame boundary always (re)starts at field 0
    always_comb begin
        w_state_nxt = r_state;
        w_kick_nxt  = 1'b0;
        if (w_frame) begin
            w_state_nxt = ST_CONV0;
            w_kick_nxt  = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_CONV0: begin
                    if (w_done_ok) begin
                        w_state_nxt = ST_CONV1;
                        w_kick_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_CONV0;
                    end
                end
                ST_CONV1: begin
                    if (w_done_ok) begin
                        w_state_nxt = ST_CONV2;
                        w_kick_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_CONV1;
                    end
                end
                ST_CONV2: begin
                    if (w_done_ok) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_CONV2;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Field selection for the converter
    always_comb begin
        w_bin = 12'd0;
        case (r_state)
            ST_CONV0: w_bin = r_snap0;
            ST_CONV1: w_bin = r_snap1;
            ST_CONV2: w_bin = r_snap2;
            default:  w_bin = 12'd0;
        endcase
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (r_kick),
        .bin   (w_bin),
        .busy  (w_bcd_busy),
        .done  (w_bcd_done),
        .bcd   (w_bcd)
    );

    // Collect field results; pending only changes once all three fields are done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work      <= 16'd0;
            r_pend      <= '0;
            r_pend_mode <= MODE_TIME;
        end else if (w_done_ok && !w_frame) begin
            case (r_state)
                ST_CONV0: r_work[7:0]  <= w_bcd[7:0];
                ST_CONV1: r_work[15:8] <= w_bcd[7:0];
                ST_CONV2: begin
                    r_pend      <= {w_bcd[7:0], r_work};
                    r_pend_mode <= r_snap_mode;
                end
                default: r_work <= r_work;
            endcase
        end else begin
            r_work <= r_work;
        end
    end

    // Digit select, decimal point and segment decode for the current index
    always_comb begin
        w_nib    = 4'h0;
        w_an_raw = 6'b000000;
        case (r_idx)
            3'd0: begin w_nib = r_disp[3:0];   w_an_raw = 6'b000001; end
            3'd1: begin w_nib = r_disp[7:4];   w_an_raw = 6'b000010; end
            3'd2: begin w_nib = r_disp[11:8];  w_an_raw = 6'b000100; end
            3'd3: begin w_nib = r_disp[15:12]; w_an_raw = 6'b001000; end
            3'd4: begin w_nib = r_disp[19:16]; w_an_raw = 6'b010000; end
            3'd5: begin w_nib = r_disp[23:20]; w_an_raw = 6'b100000; end
            default: begin w_nib = 4'h0; w_an_raw = 6'b000000; end
        endcase
        if ((r_disp_mode == MODE_TIME) && ((r_idx == 3'd2) || (r_idx == 3'd4))) begin
            w_dp = 1'b1;
        end else begin
            w_dp = 1'b0;
        end
        w_seg_raw = {w_dp, seg_decode(w_nib)};
    end

    // Register seg and an together with board polarity applied
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            seg <= SEG_ACT_LO ? ~w_seg_raw : w_seg_raw;
            an  <= SEG_ACT_LO ? ~w_an_raw  : w_an_raw;
        end
    end

    assign busy = r_busy;

endmodule

// File: tb/tb_watch_display_scan.sv
// Directed self-checking bench for watch_display_scan (SCAN_DIV=8, active-low).
// One frame is 48 cycles; cyc counts cycles since the last reset edge.
module tb_watch_display_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [11:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [5:0]  hour;
    logic [5:0]  minute;
    logic [5:0]  second;
    logic [7:0]  seg;
    logic [5:0]  an;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    watch_display_scan #(.SCAN_DIV(8), .SEG_ACT_LO(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .year   (year),
        .month  (month),
        .day    (day),
        .hour   (hour),
        .minute (minute),
        .second (second),
        .seg    (seg),
        .an     (an),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Cycle counter relative to the last reset edge
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Active-low pattern for a decimal digit, dp bit cleared when lit
    function automatic logic [7:0] exp_seg(input logic [3:0] d, input logic dp);
        logic [7:0] c;
        case (d)
            4'd0: c = 8'hC0;
            4'd1: c = 8'hF9;
            4'd2: c = 8'hA4;
            4'd3: c = 8'hB0;
            4'd4: c = 8'h99;
            4'd5: c = 8'h92;
            4'd6: c = 8'h82;
            4'd7: c = 8'hF8;
            4'd8: c = 8'h80;
            4'd9: c = 8'h90;
            default: c = 8'hFF;
        endcase
        if (dp) c = c & 8'h7F;
        return c;
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Sample every digit of frame f mid-hold; digs holds digits 5..0 as nibbles
    task automatic check_frame(input string tag, input int f, input logic [23:0] digs,
                               input logic time_page);
        int         target;
        logic [5:0] a;
        logic [3:0] dg;
        for (int d = 0; d < 6; d++) begin
            target = 48*f + 8*d + 4;
            wait_cyc(target);
            check_eq($sformatf("%s_d%0d_sched", tag, d), 16'(cyc), 16'(target));
            a  = 6'h3F ^ (6'h01 << d);
            dg = digs[4*d +: 4];
            check_eq($sformatf("%s_d%0d_an", tag, d), 16'(an), 16'(a));
            check_eq($sformatf("%s_d%0d_seg", tag, d), 16'(seg),
                     16'(exp_seg(dg, time_page && (d == 2 || d == 4))));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mode = 1'b0;
        year = 12'd0; month = 4'd0; day = 5'd0;
        hour = 6'd13; minute = 6'd45; second = 6'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_seg",  16'(seg),  16'h00FF);
        check_eq("rst_an",   16'(an),   16'h003F);
        check_eq("rst_busy", 16'(busy), 16'h0000);
        rst = 1'b0;

        wait_cyc(4);
        check_eq("conv0_busy", 16'(busy), 16'h0001);
        check_frame("f0_zero", 0, 24'h000000, 1'b1);
        wait_cyc(46);
        check_eq("conv0_idle", 16'(busy), 16'h0000);
        check_frame("f1_time", 1, 24'h134507, 1'b1);

        wait_cyc(100);
        check_eq("minchg_busy", 16'(busy), 16'h0001);
        minute = 6'd46;
        check_frame("f3_old_min", 3, 24'h134507, 1'b1);
        check_frame("f4_new_min", 4, 24'h134607, 1'b1);

        wait_cyc(260);
        check_eq("toggle_busy", 16'(busy), 16'h0001);
        mode = 1'b1; year = 12'd2021; month = 4'd1; day = 5'd30;
        check_frame("f6_still_time", 6, 24'h134607, 1'b1);
        check_frame("f7_date", 7, 24'h210130, 1'b0);

        wait_cyc(389);
        check_eq("abort_busy_pre", 16'(busy), 16'h0001);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", 16'(busy), 16'h0000);
        check_eq("abort_seg",  16'(seg),  16'h00FF);
        check_eq("abort_an",   16'(an),   16'h003F);
        @(negedge clk);
        year = 12'd1999; month = 4'd12; day = 5'd31;
        rst = 1'b0;
        check_frame("r_f0_zero", 0, 24'h000000, 1'b1);
        check_frame("r_f1_date", 1, 24'h991231, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
